// File: rtl/mic_clk_ctrl_if.sv
// Control and status bundle of the microphone clock controller.
// The bench side drives requests through master; the controller attaches as slave.
interface mic_clk_ctrl_if #(
  parameter int HALF_W = 8,
  parameter int DEC_W  = 8
);
  logic              run;
  logic [HALF_W-1:0] cfg_half;
  logic              cfg_load;
  logic              cfg_ack;
  logic [DEC_W-1:0]  dec_len;
  logic              mic_clk;
  logic              rise_stb;
  logic              fall_stb;
  logic              frame_stb;
  logic              active;

  modport master (
    output run, cfg_half, cfg_load, dec_len,
    input  cfg_ack, mic_clk, rise_stb, fall_stb, frame_stb, active
  );

  modport slave (
    input  run, cfg_half, cfg_load, dec_len,
    output cfg_ack, mic_clk, rise_stb, fall_stb, frame_stb, active
  );
endinterface

// File: rtl/mic_clk_ctrl.sv
// Divided microphone clock generator with glitch-free start/stop, boundary-safe
// divisor reload, and og_clk-domain edge and frame strobes.
module mic_clk_ctrl #(
  parameter int HALF_W   = 8,
  parameter int DEF_HALF = 49,
  parameter int DEC_W    = 8
) (
  input  logic           og_clk,
  input  logic           rst,
  mic_clk_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [HALF_W-1:0] cnt_r, cnt_nxt_s;
  logic [HALF_W-1:0] half_r, pend_val_r;
  logic              pend_r;
  logic [DEC_W-1:0]  frame_cnt_r, frame_nxt_s, len_r, len_sel_s, eff_len_s, frame_inc_s;
  logic              mic_clk_r, mic_nxt_s;
  logic              rise_r, fall_r, frame_r, ack_r, active_r;
  logic              hit_s, stop_low_s, rise_evt_s, fall_evt_s, apply_s, frame_hit_s;

  function automatic logic [HALF_W-1:0] clamp_half(input logic [HALF_W-1:0] v);
    if (v == {HALF_W{1'b0}}) begin
      clamp_half = HALF_W'(1'b1);
    end else begin
      clamp_half = v;
    end
  endfunction

  // A stop request during the low phase ends the clock at once; the low level just continues.
  assign hit_s       = (state_r != ST_IDLE) && (cnt_r == half_r);
  assign stop_low_s  = (state_r == ST_RUN) && !bus.run && !mic_clk_r;
  assign rise_evt_s  = hit_s && !mic_clk_r && !stop_low_s;
  assign fall_evt_s  = hit_s && mic_clk_r;
  assign apply_s     = pend_r && ((state_r == ST_IDLE) || fall_evt_s);
  assign frame_inc_s = frame_cnt_r + DEC_W'(1'b1);

  // State register
  always_ff @(posedge og_clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a stop while high waits for the falling edge
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.run) state_nxt_s = ST_RUN;
        else         state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (bus.run)                        state_nxt_s = ST_RUN;
        else if (!mic_clk_r || fall_evt_s)  state_nxt_s = ST_IDLE;
        else                                state_nxt_s = ST_STOP;
      end
      ST_STOP: begin
        if (bus.run)         state_nxt_s = ST_RUN;
        else if (fall_evt_s) state_nxt_s = ST_IDLE;
        else                 state_nxt_s = ST_STOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Frame length is latched at the start of each frame; zero means one rise per frame
  always_comb begin
    len_sel_s = (frame_cnt_r == {DEC_W{1'b0}}) ? bus.dec_len : len_r;
    if (len_sel_s == {DEC_W{1'b0}}) begin
      eff_len_s = DEC_W'(1'b1);
    end else begin
      eff_len_s = len_sel_s;
    end
  end

  // Output logic: next values of the divider, mic_clk and frame counter
  always_comb begin
    cnt_nxt_s = {HALF_W{1'b0}};
    mic_nxt_s = 1'b0;
    if (state_r == ST_IDLE || stop_low_s) begin
      cnt_nxt_s = {HALF_W{1'b0}};
      mic_nxt_s = 1'b0;
    end else if (hit_s) begin
      cnt_nxt_s = {HALF_W{1'b0}};
      mic_nxt_s = ~mic_clk_r;
    end else begin
      cnt_nxt_s = cnt_r + HALF_W'(1'b1);
      mic_nxt_s = mic_clk_r;
    end

    frame_hit_s = 1'b0;
    frame_nxt_s = frame_cnt_r;
    if (state_r == ST_IDLE) begin
      frame_nxt_s = {DEC_W{1'b0}};
    end else if (rise_evt_s && (frame_inc_s == eff_len_s)) begin
      frame_hit_s = 1'b1;
      frame_nxt_s = {DEC_W{1'b0}};
    end else if (rise_evt_s) begin
      frame_nxt_s = frame_inc_s;
    end else begin
      frame_nxt_s = frame_cnt_r;
    end
  end

  // Datapath registers; the strobes land in the first cycle of the new level
  always_ff @(posedge og_clk) begin
    if (!rst) begin
      cnt_r       <= {HALF_W{1'b0}};
      mic_clk_r   <= 1'b0;
      rise_r      <= 1'b0;
      fall_r      <= 1'b0;
      frame_r     <= 1'b0;
      ack_r       <= 1'b0;
      active_r    <= 1'b0;
      half_r      <= HALF_W'(DEF_HALF);
      pend_val_r  <= {HALF_W{1'b0}};
      pend_r      <= 1'b0;
      frame_cnt_r <= {DEC_W{1'b0}};
      len_r       <= {DEC_W{1'b0}};
    end else begin
      cnt_r       <= cnt_nxt_s;
      mic_clk_r   <= mic_nxt_s;
      rise_r      <= rise_evt_s;
      fall_r      <= fall_evt_s;
      frame_r     <= frame_hit_s;
      ack_r       <= apply_s;
      active_r    <= (state_nxt_s != ST_IDLE);
      frame_cnt_r <= frame_nxt_s;
      if (frame_cnt_r == {DEC_W{1'b0}}) begin
        len_r <= bus.dec_len;
      end else begin
        len_r <= len_r;
      end
      // A load arriving while a value is pending, including its apply cycle, is dropped
      if (apply_s) begin
        half_r <= pend_val_r;
        pend_r <= 1'b0;
      end else if (bus.cfg_load && !pend_r) begin
        pend_val_r <= clamp_half(bus.cfg_half);
        pend_r     <= 1'b1;
      end else begin
        pend_r <= pend_r;
      end
    end
  end

  assign bus.mic_clk   = mic_clk_r;
  assign bus.rise_stb  = rise_r;
  assign bus.fall_stb  = fall_r;
  assign bus.frame_stb = frame_r;
  assign bus.cfg_ack   = ack_r;
  assign bus.active    = active_r;

endmodule

// File: tb/tb_mic_clk_ctrl.sv
// Directed bench for mic_clk_ctrl: a phase-length model is compared every cycle,
// and hand-computed latencies and periods pin the model itself.
module tb_mic_clk_ctrl;

  logic og_clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 og_clk = ~og_clk;

  mic_clk_ctrl_if #(.HALF_W(8), .DEC_W(8)) bus ();

  mic_clk_ctrl #(.HALF_W(8), .DEF_HALF(49), .DEC_W(8)) dut (
    .og_clk (og_clk),
    .rst    (rst),
    .bus    (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each level lasts half+1 cycles; a stop takes effect at the next low level.
  bit m_seen_rst = 1'b0;
  bit m_on, m_lvl, m_pend;
  bit e_rise, e_fall, e_frame, e_ack;
  int m_age, m_half, m_pval, m_frames;

  always @(posedge og_clk) begin : model
    bit ending, apply, load_ok;
    int eff;
    if (!rst) begin
      m_on = 0; m_lvl = 0; m_age = 0; m_half = 49; m_pend = 0; m_pval = 0; m_frames = 0;
      e_rise = 0; e_fall = 0; e_frame = 0; e_ack = 0;
      m_seen_rst = 1'b1;
    end else begin
      ending  = m_on && (m_age == m_half + 1);
      apply   = m_pend && (!m_on || (ending && m_lvl));
      load_ok = bus.cfg_load && !m_pend;
      e_rise = 0; e_fall = 0; e_frame = 0; e_ack = apply;
      if (apply) begin
        m_half = m_pval;
        m_pend = 0;
      end
      if (load_ok) begin
        m_pend = 1;
        m_pval = (bus.cfg_half == 8'd0) ? 1 : int'(bus.cfg_half);
      end
      if (!m_on) begin
        m_lvl = 0; m_age = 1; m_frames = 0; m_on = bus.run;
      end else if (!bus.run && !m_lvl) begin
        m_on = 0;
      end else if (ending) begin
        m_lvl = !m_lvl;
        m_age = 1;
        if (m_lvl) begin
          e_rise = 1;
          m_frames++;
          eff = (bus.dec_len == 8'd0) ? 1 : int'(bus.dec_len);
          if (m_frames >= eff) begin
            e_frame  = 1;
            m_frames = 0;
          end
        end else begin
          e_fall = 1;
          if (!bus.run) m_on = 0;
        end
      end else begin
        m_age++;
      end
    end
  end

  always @(negedge og_clk) begin : compare
    if (m_seen_rst) begin
      chk("mic_clk",   bus.mic_clk,   m_lvl);
      chk("active",    bus.active,    m_on);
      chk("rise_stb",  bus.rise_stb,  e_rise);
      chk("fall_stb",  bus.fall_stb,  e_fall);
      chk("frame_stb", bus.frame_stb, e_frame);
      chk("cfg_ack",   bus.cfg_ack,   e_ack);
    end
  end

  function automatic logic sel(input int w);
    case (w)
      0:       sel = bus.rise_stb;
      1:       sel = bus.fall_stb;
      2:       sel = bus.cfg_ack;
      default: sel = bus.frame_stb;
    endcase
  endfunction

  // Counts negedges until the chosen strobe is seen; an expired budget is a failure
  task automatic wait_sig(input int w, input int budget, output int n);
    n = 0;
    do begin
      @(negedge og_clk);
      n++;
    end while (!sel(w) && n < budget);
    if (!sel(w)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_sig %0d: no strobe within %0d cycles", w, budget);
    end
  endtask

  initial begin
    int n, k, first, cnt;
    rst = 1'b0; bus.run = 1'b0; bus.cfg_half = 8'd0; bus.cfg_load = 1'b0; bus.dec_len = 8'd4;
    repeat (3) @(negedge og_clk);
    chk("rst_mic", bus.mic_clk, 1'b0);
    chk("rst_active", bus.active, 1'b0);
    chk("rst_ack", bus.cfg_ack, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge og_clk);

    // Default divisor: first rise 50 cycles after RUN entry, 50/50 duty
    bus.run = 1'b1;
    wait_sig(0, 200, n); chk("first_rise", n, 51);
    chk("active_run", bus.active, 1'b1);
    wait_sig(1, 200, n); chk("high_len", n, 50);
    wait_sig(0, 200, n); chk("low_len", n, 50);

    // Stop while high: full high phase, then idle
    bus.run = 1'b0;
    wait_sig(1, 200, n); chk("stop_high_len", n, 50);
    chk("stop_active", bus.active, 1'b0);

    // Stop while low: idle next cycle, no further pulses
    bus.run = 1'b1;
    wait_sig(0, 200, n); chk("restart_rise", n, 51);
    wait_sig(1, 200, n);
    repeat (10) @(negedge og_clk);
    bus.run = 1'b0;
    @(negedge og_clk);
    chk("stop_low_active", bus.active, 1'b0);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge og_clk);
      if (bus.mic_clk) cnt++;
    end
    chk("idle_mic_high", cnt, 0);

    // Reconfigure mid high phase; the second load is dropped
    bus.run = 1'b1;
    wait_sig(0, 200, n);
    repeat (10) @(negedge og_clk);
    bus.cfg_half = 8'd9; bus.cfg_load = 1'b1;
    @(negedge og_clk); bus.cfg_load = 1'b0;
    repeat (5) @(negedge og_clk);
    bus.cfg_half = 8'd20; bus.cfg_load = 1'b1;
    @(negedge og_clk); bus.cfg_load = 1'b0;
    wait_sig(1, 200, n); chk("ack_with_fall", bus.cfg_ack, 1'b1);
    wait_sig(0, 200, n); chk("new_low_len", n, 10);
    wait_sig(1, 200, n); chk("new_high_len", n, 10);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge og_clk);
      if (bus.cfg_ack) cnt++;
    end
    chk("no_second_ack", cnt, 0);

    // Frames: partial frame discarded across a stop, then four fresh rises
    wait_sig(1, 200, n);
    bus.run = 1'b0;
    repeat (3) @(negedge og_clk);
    bus.run = 1'b1;
    wait_sig(0, 200, n);
    wait_sig(0, 200, n);
    wait_sig(1, 200, n);
    bus.run = 1'b0;
    repeat (3) @(negedge og_clk);
    bus.run = 1'b1;
    first = 0;
    for (k = 1; k <= 8 && first == 0; k++) begin
      wait_sig(0, 200, n);
      if (bus.frame_stb) first = k;
    end
    chk("first_frame_rise", first, 4);
    bus.dec_len = 8'd0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      wait_sig(0, 200, n);
      if (bus.frame_stb) cnt++;
    end
    chk("len0_frames", cnt, 3);

    // Reset while high with a value pending: everything back to defaults
    repeat (3) @(negedge og_clk);
    bus.cfg_half = 8'd30; bus.cfg_load = 1'b1;
    @(negedge og_clk); bus.cfg_load = 1'b0;
    wait_sig(0, 200, n);
    repeat (2) @(negedge og_clk);
    rst = 1'b0;
    @(negedge og_clk);
    chk("rst_mid_mic", bus.mic_clk, 1'b0);
    chk("rst_mid_active", bus.active, 1'b0);
    rst = 1'b1;
    wait_sig(0, 200, n); chk("rst_default_rise", n, 51);
    bus.run = 1'b0;
    wait_sig(1, 200, n);
    repeat (3) @(negedge og_clk);

    // Zero half-period clamps to 1: ack two cycles after the load, 4-cycle period
    bus.cfg_half = 8'd0; bus.cfg_load = 1'b1;
    @(negedge og_clk); bus.cfg_load = 1'b0;
    wait_sig(2, 20, n); chk("idle_ack_lat", n, 1);
    bus.run = 1'b1;
    wait_sig(0, 50, n);
    wait_sig(1, 50, n); chk("min_high_len", n, 2);
    wait_sig(0, 50, n); chk("min_low_len", n, 2);
    bus.run = 1'b0;
    repeat (10) @(negedge og_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mic_clk_ctrl.md
Name: mic_clk_ctrl

Overview:
Controller that generates, sequences and reconfigures the divided microphone/sample clock for the recorder datapath. It derives mic_clk from og_clk using a programmable half-period. It starts and stops the clock without producing runt pulses, and applies divisor changes only at safe period boundaries. It also emits og_clk-domain edge and frame strobes, which the capture and decimation logic uses instead of clocking on mic_clk.

Parameters:
HALF_W, 8, width of the half-period register and counter
DEF_HALF, 49, reset half-period value; 100 MHz og_clk gives 1 MHz mic_clk
DEC_W, 8, width of the frame (decimation) length and counter

Ports:
og_clk  in  1  system clock; the only clock
rst  in  1  synchronous, active-low reset
run  in  1  level request: 1 = clock running, 0 = stop
cfg_half  in  HALF_W  requested half-period minus 1, in og_clk cycles
cfg_load  in  1  one-cycle strobe; captures cfg_half into the pending register
cfg_ack  out  1  one-cycle pulse in the cycle the pending value takes effect
dec_len  in  DEC_W  mic_clk rising edges per frame
mic_clk  out  1  divided clock, registered
rise_stb  out  1  one-cycle pulse coincident with the first og_clk cycle mic_clk==1
fall_stb  out  1  one-cycle pulse coincident with the first og_clk cycle mic_clk==0 after a high phase
frame_stb  out  1  one-cycle pulse on the rise_stb that completes a frame
active  out  1  1 while in RUN or STOPPING

Behaviour:
- Reset (rst==0 at an og_clk edge):
  - state=IDLE, mic_clk=0, cnt=0, frame_cnt=0.
  - half_reg=DEF_HALF; pending flag cleared.
  - rise_stb, fall_stb, frame_stb, cfg_ack, active all 0.
  - Reset mid-operation drops mic_clk immediately (accepted runt).
- States:
  - IDLE: mic_clk held 0, cnt=0, frame_cnt=0. run==1 -> RUN next cycle.
  - RUN: cnt increments each cycle. When cnt==half_reg: cnt<=0 and mic_clk toggles.
    - Period = 2*(half_reg+1) cycles, duty 50%; DEF_HALF gives 100 cycles.
    - run==0 with mic_clk==0 -> IDLE next cycle; the low level simply continues, so no glitch.
    - run==0 with mic_clk==1 -> STOPPING.
  - STOPPING: toggles as in RUN.
    - The cycle that drives mic_clk 1->0 -> IDLE; fall_stb still pulses.
    - run==1 again before then -> RUN with no interruption of the period.
- Strobes: rise_stb/fall_stb are registered alongside mic_clk, so they are high exactly in the first cycle of the new level.
- Config handshake:
  - cfg_load with no pending value: capture cfg_half, set pending.
  - cfg_load while pending: ignored, and produces no ack.
  - Apply in IDLE: next cycle.
  - Apply in RUN/STOPPING: in the cycle mic_clk toggles 1->0, so the new half_reg governs the following low phase.
  - On apply: half_reg<=pending value, pending cleared, cfg_ack pulses once (same cycle as fall_stb when running).
  - cfg_half==0 is clamped to 1 (minimum period 4 cycles).
  - cfg_load coincident with apply of an earlier value is ignored.
- Frames:
  - frame_cnt increments on each rise_stb.
  - When the incremented value reaches eff_len: frame_stb pulses with that rise_stb and frame_cnt<=0. eff_len = dec_len, or 1 when dec_len==0.
  - dec_len is sampled whenever frame_cnt==0.
  - frame_cnt clears in IDLE, so a partial frame is discarded.
- Simultaneous events: cfg_load and run changes in the same cycle are independent; stop takes precedence only over the state, never over a pending apply.

Test Plan:
1. Reset, run=1, defaults -> mic_clk period 100 og_clk cycles, high 50 / low 50; first rise_stb 50 cycles after RUN entry; active=1.
2. RUN, cfg_half=9 + cfg_load mid high phase -> cfg_ack coincident with next fall_stb; subsequent period 20 cycles; second cfg_load before ack is ignored (exactly one ack).
3. run drops while mic_clk=1 -> high phase completes full 50 cycles, then IDLE, active=0. Run drops while mic_clk=0 -> IDLE next cycle, mic_clk stays 0, no pulse shorter than half_reg+1.
4. dec_len=4 -> frame_stb on every 4th rise_stb. dec_len=0 -> frame_stb on every rise_stb. Stop after 2 rises then restart -> first frame_stb after 4 new rises.
5. rst=0 asserted with mic_clk=1 mid-frame -> next cycle all outputs 0, half_reg=49, pending cleared. cfg_half=0 loaded in IDLE -> ack next cycle, period 4 cycles.
